// File: rtl/tlb_op_ctrl_if.sv
// rtl/tlb_op_ctrl_if.sv - request/acknowledge bus between the TLB op sequencer and the TLB array
interface tlb_op_ctrl_if #(
  parameter int IDXW = 4
);
  logic            tlb_req;
  logic [1:0]      tlb_op;
  logic [IDXW-1:0] tlb_idx;
  logic            tlb_ack;

  modport master (output tlb_req, output tlb_op, output tlb_idx, input tlb_ack);
  modport slave  (input tlb_req, input tlb_op, input tlb_idx, output tlb_ack);
endinterface

// File: rtl/tlb_op_ctrl.sv
// rtl/tlb_op_ctrl.sv - MS-stage sequencer for TLBP/TLBR/TLBWI/TLBWR plus the CP0 Random counter
module tlb_op_ctrl #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = 4,
  parameter int WIRED  = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ms_valid,
  input  logic              ms_ex,
  input  logic              pipe_flush,
  input  logic              ms_inst_tlbp,
  input  logic              ms_inst_tlbr,
  input  logic              ms_inst_tlbwi,
  input  logic              ms_inst_tlbwr,
  input  logic [31:0]       ms_pc,
  input  logic [IDXW-1:0]   cp0_index,
  tlb_op_ctrl_if.master     tlb,
  output logic              cp0_tlbp_we,
  output logic              cp0_tlbr_we,
  output logic              ms_tlb_stall,
  output logic              refetch_flush,
  output logic [31:0]       refetch_pc,
  output logic [IDXW-1:0]   cp0_random
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_UPD, S_FLUSH} state_t;

  localparam logic [1:0]      OP_PROBE  = 2'b00;
  localparam logic [1:0]      OP_READ   = 2'b01;
  localparam logic [1:0]      OP_WRITE  = 2'b10;
  localparam logic [IDXW-1:0] RAND_TOP  = IDXW'(TLBNUM - 1);
  localparam logic [IDXW-1:0] WIRED_IDX = IDXW'(WIRED);

  state_t          state_q, state_d;
  logic            tlb_req_q, tlb_req_d;
  logic [1:0]      tlb_op_q, tlb_op_d;
  logic [IDXW-1:0] tlb_idx_q, tlb_idx_d;
  logic            cp0_tlbp_we_q, cp0_tlbp_we_d;
  logic            cp0_tlbr_we_q, cp0_tlbr_we_d;
  logic            refetch_flush_q, refetch_flush_d;
  logic [31:0]     refetch_pc_q, refetch_pc_d;
  logic [IDXW-1:0] random_q, random_d;

  logic            any_op;
  logic            start;
  logic [1:0]      start_op;
  logic [IDXW-1:0] start_idx;

  assign any_op = ms_inst_tlbp | ms_inst_tlbr | ms_inst_tlbwi | ms_inst_tlbwr;
  assign start  = resetn & ms_valid & ~ms_ex & ~pipe_flush & any_op & (state_q == S_IDLE);

  assign start_op  = ms_inst_tlbp ? OP_PROBE : (ms_inst_tlbr ? OP_READ : OP_WRITE);
  assign start_idx = ms_inst_tlbwr ? random_q : cp0_index;

  always_comb begin
    state_d         = state_q;
    tlb_req_d       = tlb_req_q;
    tlb_op_d        = tlb_op_q;
    tlb_idx_d       = tlb_idx_q;
    cp0_tlbp_we_d   = 1'b0;
    cp0_tlbr_we_d   = 1'b0;
    refetch_flush_d = 1'b0;
    refetch_pc_d    = refetch_pc_q;
    random_d        = random_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_REQ;
          tlb_req_d    = 1'b1;
          tlb_op_d     = start_op;
          tlb_idx_d    = start_idx;
          refetch_pc_d = ms_pc + 32'd4;
        end
      end
      S_REQ: begin
        if (tlb.tlb_ack) begin
          state_d       = S_UPD;
          tlb_req_d     = 1'b0;
          cp0_tlbp_we_d = (tlb_op_q == OP_PROBE);
          cp0_tlbr_we_d = (tlb_op_q == OP_READ);
        end
      end
      S_UPD: begin
        state_d         = (tlb_op_q == OP_PROBE) ? S_IDLE : S_FLUSH;
        refetch_flush_d = (tlb_op_q != OP_PROBE);
      end
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Frozen from the accept cycle onward so a TLBWR writes the index it captured.
    if (state_q == S_IDLE && !start) begin
      random_d = (random_q <= WIRED_IDX) ? RAND_TOP : random_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= S_IDLE;
      tlb_req_q       <= 1'b0;
      tlb_op_q        <= OP_PROBE;
      tlb_idx_q       <= '0;
      cp0_tlbp_we_q   <= 1'b0;
      cp0_tlbr_we_q   <= 1'b0;
      refetch_flush_q <= 1'b0;
      refetch_pc_q    <= '0;
      random_q        <= RAND_TOP;
    end else begin
      state_q         <= state_d;
      tlb_req_q       <= tlb_req_d;
      tlb_op_q        <= tlb_op_d;
      tlb_idx_q       <= tlb_idx_d;
      cp0_tlbp_we_q   <= cp0_tlbp_we_d;
      cp0_tlbr_we_q   <= cp0_tlbr_we_d;
      refetch_flush_q <= refetch_flush_d;
      refetch_pc_q    <= refetch_pc_d;
      random_q        <= random_d;
    end
  end

  // A TLBP retires in its UPD cycle; the other ops retire in FLUSH.
  assign ms_tlb_stall = start | (state_q == S_REQ) | ((state_q == S_UPD) & (tlb_op_q != OP_PROBE));

  assign tlb.tlb_req    = tlb_req_q;
  assign tlb.tlb_op     = tlb_op_q;
  assign tlb.tlb_idx    = tlb_idx_q;
  assign cp0_tlbp_we    = cp0_tlbp_we_q;
  assign cp0_tlbr_we    = cp0_tlbr_we_q;
  assign refetch_flush  = refetch_flush_q;
  assign refetch_pc     = refetch_pc_q;
  assign cp0_random     = random_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb/tb_tlb_op_ctrl.sv - vector table, corner sequences and randomized model check for tlb_op_ctrl
module tb_tlb_op_ctrl;
  localparam int TLBNUM = 16;
  localparam int IDXW   = 4;
  localparam int WIRED  = 0;

  localparam logic [3:0] N = 4'b0000, P = 4'b0001, R = 4'b0010, WI = 4'b0100, WR = 4'b1000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ms_valid, ms_ex, pipe_flush;
  logic        ms_inst_tlbp, ms_inst_tlbr, ms_inst_tlbwi, ms_inst_tlbwr;
  logic [31:0] ms_pc;
  logic [3:0]  cp0_index;
  logic        cp0_tlbp_we, cp0_tlbr_we, ms_tlb_stall, refetch_flush;
  logic [31:0] refetch_pc;
  logic [3:0]  cp0_random;

  tlb_op_ctrl_if #(.IDXW(IDXW)) tlb_if ();

  tlb_op_ctrl #(.TLBNUM(TLBNUM), .IDXW(IDXW), .WIRED(WIRED)) dut (
    .clk(clk), .resetn(resetn),
    .ms_valid(ms_valid), .ms_ex(ms_ex), .pipe_flush(pipe_flush),
    .ms_inst_tlbp(ms_inst_tlbp), .ms_inst_tlbr(ms_inst_tlbr),
    .ms_inst_tlbwi(ms_inst_tlbwi), .ms_inst_tlbwr(ms_inst_tlbwr),
    .ms_pc(ms_pc), .cp0_index(cp0_index),
    .tlb(tlb_if),
    .cp0_tlbp_we(cp0_tlbp_we), .cp0_tlbr_we(cp0_tlbr_we),
    .ms_tlb_stall(ms_tlb_stall), .refetch_flush(refetch_flush),
    .refetch_pc(refetch_pc), .cp0_random(cp0_random)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic v, ex, pf;
    logic [3:0] op;
    logic [31:0] pc;
    logic [3:0] idx;
    logic ack;
    logic e_req;
    logic [1:0] e_op;
    logic [3:0] e_idx;
    logic e_pwe, e_rwe, e_stall, e_rf;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(input int v, ex, pf, input logic [3:0] op, input logic [31:0] pc,
                              input int idx, ack, rq, eo, ei, pw, rw, st, rf, input logic [31:0] rpc);
    vec_t t;
    t.v = 1'(v); t.ex = 1'(ex); t.pf = 1'(pf); t.op = op; t.pc = pc; t.idx = 4'(idx); t.ack = 1'(ack);
    t.e_req = 1'(rq); t.e_op = 2'(eo); t.e_idx = 4'(ei); t.e_pwe = 1'(pw); t.e_rwe = 1'(rw);
    t.e_stall = 1'(st); t.e_rf = 1'(rf); t.e_rpc = rpc;
    return t;
  endfunction

  function automatic int rnd_next(input int v);
    return (v <= WIRED) ? TLBNUM - 1 : v - 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, ex, pf, input logic [3:0] op, input logic [31:0] pc,
                        input logic [3:0] idx, input logic ack);
    ms_valid = v; ms_ex = ex; pipe_flush = pf;
    ms_inst_tlbp = op[0]; ms_inst_tlbr = op[1]; ms_inst_tlbwi = op[2]; ms_inst_tlbwr = op[3];
    ms_pc = pc; cp0_index = idx; tlb_if.tlb_ack = ack;
  endtask

  task automatic step(input logic v, ex, pf, input logic [3:0] op, input logic [31:0] pc,
                      input logic [3:0] idx, input logic ack);
    @(posedge clk);
    #1 set_in(v, ex, pf, op, pc, idx, ack);
    @(negedge clk);
  endtask

  // Leaves resetn released in the low phase; that partial cycle is "cycle 0" with Random at its top.
  task automatic do_reset();
    resetn = 1'b0;
    set_in(0, 0, 0, N, 32'h0, 4'h0, 0);
    @(posedge clk);
    #1;
    chk("rst_req", tlb_if.tlb_req, 0);
    chk("rst_op", tlb_if.tlb_op, 0);
    chk("rst_idx", tlb_if.tlb_idx, 0);
    chk("rst_pwe", cp0_tlbp_we, 0);
    chk("rst_rwe", cp0_tlbr_we, 0);
    chk("rst_stall", ms_tlb_stall, 0);
    chk("rst_rf", refetch_flush, 0);
    chk("rst_rpc", refetch_pc, 0);
    chk("rst_random", cp0_random, TLBNUM - 1);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    set_in(0, 0, 0, N, 32'h0, 4'h0, 0);

    //        v ex pf op  pc           idx ack | req op idx pwe rwe stall rf rpc
    tbl[0]  = mk(1, 1, 0, R,  32'h0,        0, 0,  0, 0, 0, 0, 0, 0, 0, 32'h0);
    tbl[1]  = mk(1, 0, 1, R,  32'h0,        0, 0,  0, 0, 0, 0, 0, 0, 0, 32'h0);
    tbl[2]  = mk(1, 0, 0, P,  32'h100,      0, 0,  0, 0, 0, 0, 0, 1, 0, 32'h0);
    tbl[3]  = mk(1, 0, 0, P,  32'h100,      0, 0,  1, 0, 0, 0, 0, 1, 0, 32'h104);
    tbl[4]  = mk(1, 0, 0, P,  32'h100,      0, 1,  1, 0, 0, 0, 0, 1, 0, 32'h104);
    tbl[5]  = mk(0, 0, 0, N,  32'h0,        0, 0,  0, 0, 0, 1, 0, 0, 0, 32'h104);
    tbl[6]  = mk(0, 0, 0, N,  32'h0,        0, 1,  0, 0, 0, 0, 0, 0, 0, 32'h104);
    tbl[7]  = mk(1, 0, 0, WI, 32'hBFC00100, 5, 0,  0, 0, 0, 0, 0, 1, 0, 32'h104);
    tbl[8]  = mk(1, 0, 0, WI, 32'hBFC00100, 5, 1,  1, 2, 5, 0, 0, 1, 0, 32'hBFC00104);
    tbl[9]  = mk(0, 0, 0, N,  32'h0,        0, 1,  0, 0, 0, 0, 0, 1, 0, 32'hBFC00104);
    tbl[10] = mk(0, 0, 0, N,  32'h0,        0, 1,  0, 0, 0, 0, 0, 0, 1, 32'hBFC00104);
    tbl[11] = mk(0, 0, 0, N,  32'h0,        0, 0,  0, 0, 0, 0, 0, 0, 0, 32'hBFC00104);
    tbl[12] = mk(1, 0, 0, R,  32'h1000,     3, 0,  0, 0, 0, 0, 0, 1, 0, 32'hBFC00104);
    tbl[13] = mk(1, 1, 1, R,  32'h1000,     3, 0,  1, 1, 3, 0, 0, 1, 0, 32'h1004);
    tbl[14] = mk(1, 0, 1, R,  32'h1000,     3, 1,  1, 1, 3, 0, 0, 1, 0, 32'h1004);
    tbl[15] = mk(1, 0, 1, R,  32'h1000,     3, 1,  0, 0, 0, 0, 1, 1, 0, 32'h1004);
    tbl[16] = mk(1, 0, 1, R,  32'h1000,     3, 0,  0, 0, 0, 0, 0, 0, 1, 32'h1004);
    tbl[17] = mk(1, 0, 1, R,  32'h1000,     3, 0,  0, 0, 0, 0, 0, 0, 0, 32'h1004);
    tbl[18] = mk(1, 0, 0, P,  32'hFFFFFFF8, 0, 0,  0, 0, 0, 0, 0, 1, 0, 32'h1004);
    tbl[19] = mk(1, 0, 0, P,  32'hFFFFFFF8, 0, 1,  1, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFC);
    tbl[20] = mk(1, 0, 0, WI, 32'hFFFFFFFC, 7, 0,  0, 0, 0, 1, 0, 0, 0, 32'hFFFFFFFC);
    tbl[21] = mk(1, 0, 0, WI, 32'hFFFFFFFC, 7, 0,  0, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFC);
    tbl[22] = mk(1, 0, 0, WI, 32'hFFFFFFFC, 7, 1,  1, 2, 7, 0, 0, 1, 0, 32'h0);
    tbl[23] = mk(0, 0, 0, N,  32'h0,        0, 0,  0, 0, 0, 0, 0, 1, 0, 32'h0);
    tbl[24] = mk(0, 0, 0, N,  32'h0,        0, 0,  0, 0, 0, 0, 0, 0, 1, 32'h0);
    tbl[25] = mk(0, 0, 0, N,  32'h0,        0, 0,  0, 0, 0, 0, 0, 0, 0, 32'h0);

    do_reset();
    for (int i = 0; i < 26; i++) begin
      step(tbl[i].v, tbl[i].ex, tbl[i].pf, tbl[i].op, tbl[i].pc, tbl[i].idx, tbl[i].ack);
      chk($sformatf("tbl%0d_req", i), tlb_if.tlb_req, tbl[i].e_req);
      if (tbl[i].e_req) chk($sformatf("tbl%0d_op", i), tlb_if.tlb_op, tbl[i].e_op);
      if (tbl[i].e_req && tbl[i].e_op != 2'b00) chk($sformatf("tbl%0d_idx", i), tlb_if.tlb_idx, tbl[i].e_idx);
      chk($sformatf("tbl%0d_pwe", i), cp0_tlbp_we, tbl[i].e_pwe);
      chk($sformatf("tbl%0d_rwe", i), cp0_tlbr_we, tbl[i].e_rwe);
      chk($sformatf("tbl%0d_stall", i), ms_tlb_stall, tbl[i].e_stall);
      chk($sformatf("tbl%0d_rf", i), refetch_flush, tbl[i].e_rf);
      chk($sformatf("tbl%0d_rpc", i), refetch_pc, tbl[i].e_rpc);
    end

    // TLBWR accepted in cycle 3 after reset, then Random runs down and wraps.
    do_reset();
    step(0, 0, 0, N, 32'h0, 0, 0);      chk("wr_rand_c1", cp0_random, 14);
    step(0, 0, 0, N, 32'h0, 0, 0);      chk("wr_rand_c2", cp0_random, 13);
    step(1, 0, 0, WR, 32'h3000, 2, 0);  chk("wr_rand_c3", cp0_random, 12);
    chk("wr_stall_c3", ms_tlb_stall, 1);
    step(1, 0, 0, WR, 32'h3000, 2, 0);  chk("wr_idx_c4", tlb_if.tlb_idx, 12);
    chk("wr_op_c4", tlb_if.tlb_op, 2);  chk("wr_rand_c4", cp0_random, 12);
    step(1, 0, 0, WR, 32'h3000, 2, 1);  chk("wr_req_c5", tlb_if.tlb_req, 1);
    chk("wr_rand_c5", cp0_random, 12);
    step(0, 0, 0, N, 32'h0, 0, 0);      chk("wr_stall_upd", ms_tlb_stall, 1);
    chk("wr_rand_c6", cp0_random, 12);
    step(0, 0, 0, N, 32'h0, 0, 0);      chk("wr_rf", refetch_flush, 1);
    chk("wr_rpc", refetch_pc, 32'h3004); chk("wr_rand_c7", cp0_random, 12);
    step(0, 0, 0, N, 32'h0, 0, 0);      chk("wr_rand_c8", cp0_random, 12);
    for (int k = 1; k <= 13; k++) begin
      step(0, 0, 0, N, 32'h0, 0, 0);
      chk($sformatf("wr_rand_run%0d", k), cp0_random, (k <= 12) ? 12 - k : TLBNUM - 1);
    end

    // Reset pulse while in REQ, then a stale ack.
    do_reset();
    step(1, 0, 0, R, 32'h2000, 9, 0);
    step(1, 0, 0, R, 32'h2000, 9, 0);
    chk("rr_req_before", tlb_if.tlb_req, 1);
    #2 resetn = 1'b0;
    #1;
    chk("rr_req_async", tlb_if.tlb_req, 0);
    chk("rr_stall_async", ms_tlb_stall, 0);
    chk("rr_rand_async", cp0_random, TLBNUM - 1);
    @(posedge clk);
    #1 resetn = 1'b1;
    set_in(0, 0, 0, N, 32'h0, 0, 1);
    @(negedge clk);
    chk("rr_req_ack", tlb_if.tlb_req, 0);
    chk("rr_rand_ack", cp0_random, TLBNUM - 1);
    step(0, 0, 0, N, 32'h0, 0, 0);
    chk("rr_rwe", cp0_tlbr_we, 0);
    chk("rr_pwe", cp0_tlbp_we, 0);
    chk("rr_rf", refetch_flush, 0);
    chk("rr_rand_next", cp0_random, TLBNUM - 2);

    // Randomized run against a timeline model of each accepted operation.
    begin
      bit m_busy = 0;
      int m_op = 0, m_idx = 0, m_ackc = -1, m_rand;
      logic [31:0] m_pc4 = 32'h0;
      do_reset();
      m_rand = rnd_next(TLBNUM - 1);
      for (int c = 0; c < 2000; c++) begin
        logic v, ex, pf, ack;
        logic [3:0] op, idx;
        logic [31:0] pc;
        bit e_req, e_upd, e_fl, st, idle;
        int sel, code;
        v   = ($urandom_range(0, 9) < 7);
        ex  = ($urandom_range(0, 9) == 0);
        pf  = ($urandom_range(0, 9) == 0);
        sel = $urandom_range(0, 5);
        op  = (sel < 2) ? N : 4'(1 << (sel - 2));
        pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
        idx = 4'($urandom_range(0, 15));
        ack = ($urandom_range(0, 2) == 0);
        step(v, ex, pf, op, pc, idx, ack);

        idle  = !m_busy;
        e_req = m_busy && m_ackc < 0;
        e_upd = m_busy && m_ackc >= 0 && m_ackc == c - 1;
        e_fl  = m_busy && m_ackc >= 0 && m_ackc == c - 2;
        st    = idle && v && !ex && !pf && (op != N);
        code  = (m_op == 0) ? 0 : (m_op == 1) ? 1 : 2;

        chk("rnd_req", tlb_if.tlb_req, e_req);
        if (e_req) chk("rnd_op", tlb_if.tlb_op, code);
        if (e_req && m_op != 0) chk("rnd_idx", tlb_if.tlb_idx, m_idx);
        chk("rnd_pwe", cp0_tlbp_we, e_upd && m_op == 0);
        chk("rnd_rwe", cp0_tlbr_we, e_upd && m_op == 1);
        chk("rnd_stall", ms_tlb_stall, st || e_req || (e_upd && m_op != 0));
        chk("rnd_rf", refetch_flush, e_fl);
        chk("rnd_rpc", refetch_pc, m_pc4);
        chk("rnd_random", cp0_random, m_rand);

        if (e_req && ack) m_ackc = c;
        if (e_upd && m_op == 0) m_busy = 0;
        if (e_fl) m_busy = 0;
        if (idle && !st) m_rand = rnd_next(m_rand);
        if (st) begin
          m_busy = 1;
          m_ackc = -1;
          m_op   = op[0] ? 0 : op[1] ? 1 : op[2] ? 2 : 3;
          m_idx  = (m_op == 3) ? m_rand : int'(idx);
          m_pc4  = pc + 32'd4;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tlb_op_ctrl.md
# tlb_op_ctrl

Multi-cycle sequencer for TLB-management instructions (TLBP, TLBR, TLBWI, TLBWR) in the memory stage. It sits between the MS pipeline stage, the TLB array and CP0. On each accepted instruction it:
- stalls MS;
- issues one request/acknowledge transaction to the TLB;
- pulses the CP0 update strobes that load Index, EntryHi and EntryLo0/1;
- for TLBR, TLBWI and TLBWR, requests a refetch flush so younger instructions see the new mapping.

It also owns the Random index counter used by TLBWR.

## Interface
Parameters:
- TLBNUM, 16, number of TLB entries (power of two)
- IDXW, 4, index width, log2(TLBNUM)
- WIRED, 0, lowest index Random may produce

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- ms_valid  in  1  MS holds a valid instruction
- ms_ex  in  1  MS instruction has an exception
- pipe_flush  in  1  exception/eret flush in progress
- ms_inst_tlbp / ms_inst_tlbr / ms_inst_tlbwi / ms_inst_tlbwr  in  1 each  decoded op (one-hot or zero)
- ms_pc  in  32  PC of MS instruction
- cp0_index  in  IDXW  CP0 Index.Index field
- tlb_ack  in  1  TLB finished current request (1-cycle pulse)
- tlb_req  out  1  request to TLB, held until tlb_ack
- tlb_op  out  2  00 probe, 01 read, 10 write
- tlb_idx  out  IDXW  entry index for read/write
- cp0_tlbp_we  out  1  1-cycle strobe: CP0 loads Index.P/Index from probe result
- cp0_tlbr_we  out  1  1-cycle strobe: CP0 loads EntryHi/EntryLo0/1 from read result
- ms_tlb_stall  out  1  hold MS and older stages
- refetch_flush  out  1  1-cycle flush of younger stages
- refetch_pc  out  32  restart PC, ms_pc+4 captured at accept
- cp0_random  out  IDXW  current Random value, for mfc0

## Operation
- Start condition: `start = ms_valid & !ms_ex & !pipe_flush & (any op) & state==IDLE`.
- At start, capture:
  - op;
  - index: cp0_index for TLBR/TLBWI, cp0_random for TLBWR, don't-care for TLBP;
  - ms_pc+4.
- FSM states: IDLE, REQ, UPD, FLUSH.
  - IDLE→REQ on start.
  - REQ: tlb_req=1, tlb_op/tlb_idx from the captured values. On tlb_ack, go to UPD.
  - UPD:
    - cp0_tlbp_we=1 if op is TLBP; cp0_tlbr_we=1 if op is TLBR.
    - Go to IDLE if TLBP, otherwise to FLUSH.
  - FLUSH: refetch_flush=1 with refetch_pc valid, then go to IDLE.
- The TLB holds its result outputs stable from tlb_ack until its next request, so CP0 samples them in UPD.
- ms_tlb_stall = start | REQ | (UPD & op≠TLBP). It is low in FLUSH and in the TLBP UPD cycle; the instruction retires in that cycle.
- Once accepted, an operation cannot be aborted.
  - pipe_flush or ms_ex arriving after start does not cancel tlb_req.
  - A pipe_flush in UPD does not suppress the CP0 strobes.
  - A pipe_flush in FLUSH still produces refetch_flush. pipe_flush has priority in the front end; this block does not arbitrate.
- Random counter:
  - Reset value TLBNUM-1.
  - Decrements every cycle.
  - When it equals WIRED (or is below WIRED), the next value is TLBNUM-1.
  - It is frozen while state≠IDLE, so the TLBWR index matches the value captured at accept.
- tlb_op encoding: TLBP=00, TLBR=01, TLBWI/TLBWR=10.
- refetch_pc is computed mod 2^32 (wraps at 0xFFFFFFFC→0x00000000).

## Timing
- All state, the Random counter and the captured registers reset asynchronously on resetn=0. Reset values:
  - state=IDLE;
  - tlb_req=0, tlb_op=00, tlb_idx=0;
  - cp0_tlbp_we=0, cp0_tlbr_we=0;
  - ms_tlb_stall=0 (start is also gated by resetn);
  - refetch_flush=0, refetch_pc=0;
  - cp0_random=TLBNUM-1.
- Reset asserted mid-operation returns to IDLE immediately and drops tlb_req. A late tlb_ack is ignored in IDLE.
- Latency, with accept in cycle T and tlb_ack in cycle T+k (k≥1):
  - tlb_req is high in cycles T+1..T+k;
  - UPD is cycle T+k+1;
  - FLUSH is cycle T+k+2 (non-TLBP ops);
  - the next start is possible in cycle T+k+2 (TLBP) or T+k+3 (other ops).
- A tlb_ack in IDLE, UPD or FLUSH is ignored.
- All outputs except ms_tlb_stall are registered; ms_tlb_stall is combinational in its start term.

## Test plan
- TLBP, ack after 2 cycles → tlb_req high 2 cycles, op=00; cp0_tlbp_we pulses 1 cycle after ack; no refetch_flush; stall covers 3 cycles total.
- TLBWI with cp0_index=5, ms_pc=0xBFC00100, ack after 1 cycle → tlb_op=10, tlb_idx=5; cp0_tlbr_we and cp0_tlbp_we stay 0; refetch_flush with refetch_pc=0xBFC00104; stall low in the FLUSH cycle.
- TLBWR after reset, accepted at cycle 3, TLBNUM=16, WIRED=0 → tlb_idx=12; Random holds 12 during the op and resumes decrementing in IDLE; wrap 0→15 is observed.
- TLBR with ms_ex=1, or with pipe_flush=1 → no start, tlb_req stays 0, stall 0.
- resetn pulsed low while in REQ → tlb_req drops asynchronously; a subsequent tlb_ack produces no strobe; Random=15.
- Back-to-back TLBP then TLBWI (second held in MS) → the second starts in the cycle after the first's UPD; ms_pc 0xFFFFFFFC gives refetch_pc=0x00000000.
